// File: rtl/shared_down_timer_arbiter.sv
// rtl/shared_down_timer_arbiter.sv - one shared down-counter arbitrated among N_REQ requesters; define SDTA_ROUND_ROBIN_EN for round-robin
module shared_down_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*CNT_W-1:0]   load_val_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         Count_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     aborted_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_onehot;
    logic [CNT_W-1:0]   win_load;
    logic               owner_req;

`ifdef SDTA_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    int                 rr_idx;

    // Round-robin pick: first requester found scanning upward from ptr with wrap
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = (int'(ptr_q) + k) % N_REQ;
            if (!win_valid && req_i[rr_idx]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(rr_idx);
            end
        end
    end

    // Pointer moves past the winner on every grant
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && win_valid) begin
            ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: lowest requesting index wins
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`endif

    assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign win_load   = load_val_i[win_idx*CNT_W +: CNT_W];
    assign owner_req  = |(req_i & gnt_q);

    // Next-state logic: grant from IDLE, count down / complete / abort in RUN
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        count_d   = count_q;
        done_d    = '0;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_RUN;
                    gnt_d   = win_onehot;
                    count_d = win_load;
                end
            end
            ST_RUN: begin
                if (count_q == '0) begin
                    // Completion has priority over a simultaneous req drop
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (!owner_req) begin
                    aborted_d = 1'b1;
                    gnt_d     = '0;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // State and output registers; reset kills any run without a done pulse
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            count_q   <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            count_q   <= count_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = |gnt_q;
    assign Count_o   = count_q;
    assign done_o    = done_q;
    assign aborted_o = aborted_q;

endmodule
